// File: rtl/id_ex_reg_pkg.sv
// Shared pipeline definitions: datapath widths, immediate formats, ALU NOP code.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package id_ex_reg_pkg;

    localparam int RegBus    = 32;  // datapath width
    localparam int GPR_AW    = 5;   // general-purpose register address width
    localparam int ALU_OP_W  = 5;   // execute operation code width
    localparam int IMM_RAW_W = 20;  // raw immediate field width in the instruction

    localparam logic [ALU_OP_W-1:0] ALU_NOP = 5'd0;

    // Immediate formats selected by decode
    typedef enum logic [1:0] {
        IMM5U  = 2'd0,  // zero-extend [4:0]
        IMM15S = 2'd1,  // sign-extend [14:0]
        IMM15U = 2'd2,  // zero-extend [14:0]
        IMM20S = 2'd3   // sign-extend [19:0]
    } imm_sel_e;

    // Everything the execute stage receives from decode
    typedef struct packed {
        logic                valid;
        logic [RegBus-1:0]   op_a;
        logic [RegBus-1:0]   reg_b;
        logic [RegBus-1:0]   imm;
        logic                movsrc;
        logic [ALU_OP_W-1:0] alu_op;
        logic [GPR_AW-1:0]   wb_addr;
        logic                wb_en;
    } idex_t;

endpackage

// File: rtl/id_ex_reg_imm_ext.sv
// Widens the raw instruction immediate to RegBus according to the decoded format.
// Latency: combinational.
// Backpressure: none.
// Ports: imm_raw_i (20b raw field), imm_sel_i (format), imm_o (RegBus extended value).
module imm_ext
    import id_ex_reg_pkg::*;
(
    input  logic [IMM_RAW_W-1:0] imm_raw_i,
    input  logic [1:0]           imm_sel_i,
    output logic [RegBus-1:0]    imm_o
);

    always_comb begin
        imm_o = '0;
        case (imm_sel_e'(imm_sel_i))
            IMM5U:   imm_o = {27'd0, imm_raw_i[4:0]};
            IMM15S:  imm_o = {{17{imm_raw_i[14]}}, imm_raw_i[14:0]};
            IMM15U:  imm_o = {17'd0, imm_raw_i[14:0]};
            IMM20S:  imm_o = {{12{imm_raw_i[19]}}, imm_raw_i};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall hold, flush bubble insertion and a saturating bubble counter.
// Latency: 1 cycle from id_* inputs to ex_* outputs; no combinational input-to-output path.
// Backpressure: stall freezes every register including the counter; flush overrides stall.
// Ports: clk/rst (async active-high); stall, flush; id_* decode fields in; ex_* execute fields out;
//        bubble_cnt counts edges that loaded a bubble since reset.
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic [RegBus-1:0]    id_rs1_data,
    input  logic [RegBus-1:0]    id_rs2_data,
    input  logic [IMM_RAW_W-1:0] id_imm_raw,
    input  logic [1:0]           id_imm_sel,
    input  logic                 id_movsrc,
    input  logic [ALU_OP_W-1:0]  id_alu_op,
    input  logic [GPR_AW-1:0]    id_wb_addr,
    input  logic                 id_wb_en,
    output logic                 ex_valid,
    output logic [RegBus-1:0]    ex_op_a,
    output logic [RegBus-1:0]    ex_reg_b,
    output logic [RegBus-1:0]    ex_imm,
    output logic                 ex_movsrc,
    output logic [ALU_OP_W-1:0]  ex_alu_op,
    output logic [GPR_AW-1:0]    ex_wb_addr,
    output logic                 ex_wb_en,
    output logic [CNT_W-1:0]     bubble_cnt
);

    logic [RegBus-1:0] id_imm_ext;
    idex_t             pipe_q, pipe_d, bubble_val;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load_bubble;

    // Extension happens in decode so ex_imm leaves a flop directly
    imm_ext u_imm_ext (
        .imm_raw_i (id_imm_raw),
        .imm_sel_i (id_imm_sel),
        .imm_o     (id_imm_ext)
    );

    // An invalid decode slot is indistinguishable from a flush bubble
    assign load_bubble = flush | (~stall & ~id_valid);

    always_comb begin
        bubble_val        = '0;
        bubble_val.alu_op = ALU_NOP;
    end

    always_comb begin
        pipe_d = pipe_q;
        cnt_d  = cnt_q;
        if (load_bubble) begin
            pipe_d = bubble_val;
            // Saturate rather than wrap so a long bubble run never reads as few
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (!stall) begin
            pipe_d.valid   = id_valid;
            pipe_d.op_a    = id_rs1_data;
            pipe_d.reg_b   = id_rs2_data;
            pipe_d.imm     = id_imm_ext;
            pipe_d.movsrc  = id_movsrc;
            pipe_d.alu_op  = id_alu_op;
            pipe_d.wb_addr = id_wb_addr;
            pipe_d.wb_en   = id_wb_en & id_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= bubble_val;
            cnt_q  <= '0;
        end else begin
            pipe_q <= pipe_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ex_valid   = pipe_q.valid;
    assign ex_op_a    = pipe_q.op_a;
    assign ex_reg_b   = pipe_q.reg_b;
    assign ex_imm     = pipe_q.imm;
    assign ex_movsrc  = pipe_q.movsrc;
    assign ex_alu_op  = pipe_q.alu_op;
    assign ex_wb_addr = pipe_q.wb_addr;
    assign ex_wb_en   = pipe_q.wb_en;
    assign bubble_cnt = cnt_q;

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

ID/EX pipeline register of the in-order pipeline: it captures the decoded operands and controls from the decode stage and presents them to execute. Its outputs drive the execute-stage mov-source select: `ex_movsrc` is the select, `ex_reg_b` is input 0 and `ex_imm` is input 1. The block also widens the raw immediate field to `RegBus` width, supports stall (hold) and flush (bubble insertion), and keeps a saturating bubble counter for performance monitoring.

## Interface
- `CNT_W`, 16, width of the bubble counter
- `clk` in 1: pipeline clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `stall` in 1: hold every register, including the counter
- `flush` in 1: load a bubble on the next edge
- `id_valid` in 1: the decode stage holds a real instruction
- `id_rs1_data` in `RegBus` (32): operand A
- `id_rs2_data` in `RegBus`: operand B, register path
- `id_imm_raw` in 20: raw immediate field
- `id_imm_sel` in 2: immediate format
  - 0 = imm5u (zero-extend [4:0])
  - 1 = imm15s (sign-extend [14:0])
  - 2 = imm15u (zero-extend [14:0])
  - 3 = imm20s (sign-extend [19:0])
- `id_movsrc` in 1: 0 = register, 1 = immediate
- `id_alu_op` in 5: execute operation code
- `id_wb_addr` in 5: destination GPR
- `id_wb_en` in 1: register write-back enable
- `ex_valid` out 1
- `ex_op_a` out `RegBus`
- `ex_reg_b` out `RegBus`
- `ex_imm` out `RegBus`: extended immediate
- `ex_movsrc` out 1
- `ex_alu_op` out 5
- `ex_wb_addr` out 5
- `ex_wb_en` out 1
- `bubble_cnt` out `CNT_W`: bubbles inserted since reset

## Operation
- The immediate is extended combinationally in decode, before the register. `ex_imm` is always the registered, extended value.
- On each rising edge, the first matching rule below applies:
  - **`flush` = 1** (wins over `stall`): load a bubble.
    - `ex_valid`, `ex_wb_en`, `ex_movsrc` = 0.
    - `ex_alu_op` = `ALU_NOP` (5'd0).
    - All data outputs and `ex_wb_addr` = 0.
  - **`stall` = 1**: all outputs hold their value.
  - **Otherwise**: load the decode values.
    - `ex_valid` = `id_valid`.
    - `ex_wb_en` = `id_wb_en & id_valid`, so a write-back is never issued for an invalid slot.
    - When `id_valid` = 0 the load is a bubble, with the same field values as a flush.
- `bubble_cnt` increments by 1 on every edge that loads a bubble, whether from a flush or from a non-stalled `id_valid` = 0.
  - It saturates at all-ones and never wraps.
  - It holds during a stall.
- Reset: every output is 0, including `bubble_cnt`, and `ex_alu_op` = `ALU_NOP`. Reset is asynchronous: it takes effect immediately, even mid-stall, and overrides `flush` and `stall`.

## Timing
- Latency is 1 cycle from the decode inputs to the `ex_*` outputs. There is no combinational path from any input to any output.
- A stall of N cycles keeps the outputs constant for N edges. The instruction presented on the first non-stalled edge is the one loaded.
- `flush` and `stall` in the same cycle produce a bubble, and `bubble_cnt` increments.
- On reset deassertion, the first edge behaves as a normal load.

## Structure
- Shared pipeline package holds:
  - the `RegBus` width (32)
  - the `imm_sel_e` enum (`IMM5U`, `IMM15S`, `IMM15U`, `IMM20S`)
  - `ALU_NOP`
  - the GPR address width (5)
- One combinational sub-module, `imm_ext`: `id_imm_raw` + `id_imm_sel` → 32-bit immediate.
- Register bank and counter live in `id_ex_reg`.

## Test plan
- **Immediate extension:** `id_imm_raw` = 20'h80000 with sel = `IMM20S` → `ex_imm` = 32'hFFF80000. With sel = `IMM15U` → 32'h00000000. `id_imm_raw` = 20'h04000 with sel = `IMM15S` → 32'hFFFFC000.
- **Normal pass-through:** `id_rs1_data` = 32'h12345678, `id_movsrc` = 1, `id_wb_addr` = 5'd7, `id_valid` = 1 → one cycle later `ex_op_a` = 32'h12345678, `ex_movsrc` = 1, `ex_wb_addr` = 7, `ex_wb_en` = 1.
- **Stall:** `stall` high for 3 cycles while the inputs change → outputs frozen for 3 edges, `bubble_cnt` unchanged. The 4th edge loads the current inputs.
- **Flush priority:** `flush` = `stall` = 1 with a valid instruction → `ex_valid` = 0, `ex_wb_en` = 0, `ex_alu_op` = 0, `bubble_cnt` +1.
- **Reset mid-stall:** assert `rst` between clock edges during a stall → all outputs 0 immediately. The first edge after release loads the inputs.
- **Saturation:** with `CNT_W` = 4, run 20 bubble edges → `bubble_cnt` stops at 4'hF.
